// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// SEQ_PATTERN_TX_PARITY_EN appends an even-parity bit to every frame.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] DEFAULT_PAT = 3'b101;

`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_len(input int pat_w);
    return pat_w + PARITY_BITS;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/control and serial-output bundle of seq_pattern_tx.
// The bench (master) drives requests; the transmitter (slave) drives the line.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             ready;
  logic             o;
  logic             o_valid;
  logic             frame_start;
  logic             done;

  modport master (
    output start, pattern, repeat_n, gap, abort,
    input  ready, o, o_valid, frame_start, done
  );

  modport slave (
    input  start, pattern, repeat_n, gap, abort,
    output ready, o, o_valid, frame_start, done
  );
endinterface

// File: rtl/seq_frame_shifter.sv
// Holds the captured pattern and walks it MSB-first, one bit per advance.
// SEQ_PATTERN_TX_PARITY_EN adds a trailing even-parity bit to each frame.
module seq_frame_shifter #(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             advance_i,
  output logic             bit_o,
  output logic             first_o,
  output logic             last_o
);
  import seq_pkg::*;

  localparam int FRAME_LEN = frame_len(PAT_W);
  localparam int IDX_W     = $clog2(FRAME_LEN);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= '0;
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      pat_q <= pat_d;
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  // After the last bit the register rewinds to the pattern so the next frame needs no reload.
  always_comb begin
    pat_d = pat_q;
    sr_d  = sr_q;
    idx_d = idx_q;
    if (load_i) begin
      pat_d = pattern_i;
      sr_d  = pattern_i;
      idx_d = '0;
    end else if (advance_i) begin
      if (last_o) begin
        sr_d  = pat_q;
        idx_d = '0;
      end else begin
        sr_d  = {sr_q[PAT_W-2:0], 1'b0};
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  assign first_o = (idx_q == '0);
  assign last_o  = (idx_q == IDX_W'(FRAME_LEN - 1));

`ifdef SEQ_PATTERN_TX_PARITY_EN
  assign bit_o = (idx_q == IDX_W'(PAT_W)) ? ^pat_q : sr_q[PAT_W-1];
`else
  assign bit_o = sr_q[PAT_W-1];
`endif

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: frames, repeat count, inter-frame gap and abort.
// SEQ_PATTERN_TX_PARITY_EN (via seq_frame_shifter) lengthens each frame by a parity bit.
module seq_pattern_tx #(
  parameter int               PAT_W       = 3,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(seq_pkg::DEFAULT_PAT),
  parameter int               CNT_W       = 8,
  parameter int               GAP_W       = 4
) (
  input logic             clk,
  input logic             rst,
  seq_pattern_tx_if.slave bus
);
  import seq_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             ready_q, ready_d;
  logic             o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             done_q, done_d;

  logic             sh_load, sh_advance, sh_bit, sh_first, sh_last;
  logic [PAT_W-1:0] pat_eff;

  assign pat_eff = (bus.pattern == '0) ? DEFAULT_PAT : bus.pattern;

  seq_frame_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (sh_load),
    .pattern_i (pat_eff),
    .advance_i (sh_advance),
    .bit_o     (sh_bit),
    .first_o   (sh_first),
    .last_o    (sh_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      frames_q      <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      ready_q       <= 1'b1;
      o_q           <= 1'b0;
      o_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      frames_q      <= frames_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      ready_q       <= ready_d;
      o_q           <= o_d;
      o_valid_q     <= o_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
    end
  end

  // Accept needs ready_q as well, so the IDLE cycle right after DONE still ignores start.
  always_comb begin
    state_d       = state_q;
    frames_d      = frames_q;
    gap_d         = gap_q;
    gap_cnt_d     = gap_cnt_q;
    ready_d       = 1'b0;
    o_d           = 1'b0;
    o_valid_d     = 1'b0;
    frame_start_d = 1'b0;
    done_d        = 1'b0;
    sh_load       = 1'b0;
    sh_advance    = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (ready_q && bus.start) begin
          sh_load  = 1'b1;
          frames_d = (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
          gap_d    = bus.gap;
          ready_d  = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          o_d           = sh_bit;
          o_valid_d     = 1'b1;
          frame_start_d = sh_first;
          sh_advance    = 1'b1;
          if (sh_last) begin
            frames_d = frames_q - CNT_W'(1);
            if (frames_q == CNT_W'(1)) begin
              state_d = DONE;
            end else if (gap_q != '0) begin
              gap_cnt_d = gap_q;
              state_d   = GAP;
            end
          end
        end
      end
      GAP: begin
        if (bus.abort) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q == GAP_W'(1)) begin
            state_d = SHIFT;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready       = ready_q;
  assign bus.o           = o_q;
  assign bus.o_valid     = o_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.done        = done_q;

endmodule
